// File: rtl/rf_pkg.sv
// Shared types and the write-port priority select for the multiport register file.
// Latency: combinational helpers only.
// Backpressure: none; pure functions and constants.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // Upper bounds for the generic select function. Instances must keep
  // NUM_WR <= RF_MAX_WR and ADDR_W <= RF_MAX_AW.
  localparam int RF_MAX_WR = 8;
  localparam int RF_MAX_AW = 8;

  typedef logic [RF_MAX_AW-1:0]                rf_addr_t;
  typedef logic [RF_MAX_WR-1:0][RF_MAX_AW-1:0] rf_addr_vec_t;

  typedef struct packed {
    logic hit;  // some enabled write port targets the address
    int   idx;  // highest-index such port
  } rf_sel_t;

  // Scanning upward lets later ports overwrite earlier matches, so the
  // highest-index enabled port targeting addr wins.
  function automatic rf_sel_t rf_wr_select(input rf_addr_t              addr,
                                           input logic [RF_MAX_WR-1:0] wr_en,
                                           input rf_addr_vec_t          wr_addr);
    rf_sel_t s;
    s.hit = 1'b0;
    s.idx = 0;
    for (int j = 0; j < RF_MAX_WR; j++) begin
      if (wr_en[j] && (wr_addr[j] == addr)) begin
        s.hit = 1'b1;
        s.idx = j;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: storage mux, same-cycle write bypass, zero-register force, busy flag.
// Latency: combinational, zero cycles from rd_addr/wr_* to rd_data/rd_busy.
// Backpressure: none; always answers.
// Ports: rst (async reset, gates bypass), rd_addr, mem/pend (registered state),
//        wr_en_x/wr_addr_x (zero-extended write controls), wr_data, rd_data, rd_busy.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                                  rst,
  input  logic [ADDR_W-1:0]                     rd_addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    mem,
  input  logic [(2**ADDR_W)-1:0]                pend,
  input  logic [RF_MAX_WR-1:0]                  wr_en_x,
  input  rf_addr_vec_t                          wr_addr_x,
  input  logic [NUM_WR*DATA_W-1:0]              wr_data,
  output logic [DATA_W-1:0]                     rd_data,
  output logic                                  rd_busy
);

  rf_sel_t           w_sel;
  logic              w_is_zero;
  logic              w_byp;
  logic [DATA_W-1:0] w_byp_dat;

  always_comb begin
    w_sel     = rf_wr_select(RF_MAX_AW'(rd_addr), wr_en_x, wr_addr_x);
    w_is_zero = (ZERO_REG != 0) && (rd_addr == '0);
    // Forwarding is suppressed under reset so rd_data stays 0 whatever wr_* does.
    w_byp     = (BYPASS != 0) && !rst && w_sel.hit && !w_is_zero;

    w_byp_dat = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (w_sel.idx == j) w_byp_dat = wr_data[j*DATA_W +: DATA_W];
    end

    if (rst || w_is_zero) rd_data = '0;
    else if (w_byp)       rd_data = w_byp_dat;
    else                  rd_data = mem[rd_addr];

    // A retiring write that is being forwarded already satisfies the consumer.
    rd_busy = pend[rd_addr] && !w_byp;
  end

endmodule

// File: rtl/rf_multiport_sb.sv
// Multiport register file with per-register pending-write scoreboard for RAW detection.
// Latency: reads combinational; writes and scoreboard updates land on the next clk edge.
// Backpressure: none; every enabled write and sb_set is accepted each cycle.
// Ports: clk, rst (async active-high); rd_addr/rd_data/rd_busy per read port;
//        wr_en/wr_addr/wr_data per write port; sb_set/sb_addr mark a destination pending;
//        pend_vec exposes the whole scoreboard.
module rf_multiport_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  output logic [(2**ADDR_W)-1:0]     pend_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0]             r_pend;

  logic [RF_MAX_WR-1:0] w_en_x;
  rf_addr_vec_t         w_wa_x;
  rf_sel_t              w_wsel [DEPTH];
  logic [DATA_W-1:0]    w_wdat [DEPTH];

  // Widen write controls to the fixed shape the shared select function expects.
  always_comb begin
    w_en_x = RF_MAX_WR'(wr_en);
    w_wa_x = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      w_wa_x[j] = RF_MAX_AW'(wr_addr[j*ADDR_W +: ADDR_W]);
    end
  end

  // Per-register winning write port and its data.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      w_wsel[r] = rf_wr_select(RF_MAX_AW'(r), w_en_x, w_wa_x);
      w_wdat[r] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (w_wsel[r].idx == j) w_wdat[r] = wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem  <= '0;
      r_pend <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if ((ZERO_REG != 0) && (r == 0)) begin
          r_mem[r]  <= '0;
          r_pend[r] <= 1'b0;
        end else begin
          if (w_wsel[r].hit) r_mem[r] <= w_wdat[r];
          // Set beats clear: a newly issued producer supersedes the retiring one.
          if (sb_set && (sb_addr == ADDR_W'(r))) r_pend[r] <= 1'b1;
          else if (w_wsel[r].hit)                r_pend[r] <= 1'b0;
        end
      end
    end
  end

  assign pend_vec = r_pend;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .rst      (rst),
      .rd_addr  (rd_addr[i*ADDR_W +: ADDR_W]),
      .mem      (r_mem),
      .pend     (r_pend),
      .wr_en_x  (w_en_x),
      .wr_addr_x(w_wa_x),
      .wr_data  (wr_data),
      .rd_data  (rd_data[i*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy[i])
    );
  end

endmodule
